// File: rtl/win_avg_seq.sv
// Frame sequencer for a windowed averager: gates the source stream into the averager and counts frame beats.
// Optional DRAIN watchdog enabled by defining WIN_AVG_SEQ_TIMEOUT_EN.
module win_avg_seq #(
    parameter int streams = 16,
    parameter int bits    = 32,
    parameter int timeout = 1024
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [4:0]                cfg_win_len,
    input  logic [15:0]               cfg_frame_len,
    input  logic [bits*streams-1:0]   s_axis_di,
    input  logic                      s_axis_vi,
    output logic                      s_axis_ri,
    output logic [bits*streams-1:0]   m_axis_di,
    output logic                      m_axis_vi,
    input  logic                      m_axis_ri,
    input  logic                      avg_vo,
    input  logic                      avg_ro,
    output logic [4:0]                win_len,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state;
    logic [15:0] frame_len;
    logic [15:0] in_cnt;
    logic [15:0] out_cnt;
    logic        beat_in;
    logic        beat_out;

`ifdef WIN_AVG_SEQ_TIMEOUT_EN
    localparam int idle_w = $clog2(timeout + 1);
    logic [idle_w-1:0] idle_cnt;
`endif

    // The stream path is pure wiring; only the handshakes are gated by RUN.
    assign m_axis_di = s_axis_di;
    assign m_axis_vi = (state == S_RUN) && s_axis_vi;
    assign s_axis_ri = (state == S_RUN) && m_axis_ri;
    assign beat_in   = (state == S_RUN) && s_axis_vi && m_axis_ri;
    assign beat_out  = avg_vo && avg_ro;

    // NOTE: every register here uses non-blocking assignment so all branches see pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= S_IDLE;
            frame_len <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            win_len   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef WIN_AVG_SEQ_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
        end else if (abort) begin
            state   <= S_IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef WIN_AVG_SEQ_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            if ((state == S_RUN || state == S_DRAIN) && beat_out && out_cnt != frame_len)
                out_cnt <= out_cnt + 16'd1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_frame_len != 16'd0) begin
                            win_len   <= cfg_win_len;
                            frame_len <= cfg_frame_len;
                            err       <= 1'b0;
                            in_cnt    <= '0;
                            out_cnt   <= '0;
                            busy      <= 1'b1;
                            state     <= S_LOAD;
`ifdef WIN_AVG_SEQ_TIMEOUT_EN
                            idle_cnt  <= '0;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_LOAD: state <= S_RUN;
                S_RUN: begin
                    if (beat_in) begin
                        in_cnt <= in_cnt + 16'd1;
                        if (in_cnt == frame_len - 16'd1)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Registered compare: an output count completed in RUN costs one DRAIN cycle.
                    if (out_cnt == frame_len) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
`ifdef WIN_AVG_SEQ_TIMEOUT_EN
                    else if (beat_out) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == idle_w'(timeout - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_win_avg_seq.sv
// Self-checking bench for win_avg_seq: directed scenarios plus random frames against a cycle-level reference model.
// Define WIN_AVG_SEQ_TIMEOUT_EN on both files to also exercise the DRAIN watchdog.
module tb_win_avg_seq;

    localparam int STREAMS = 4;
    localparam int BITS    = 16;
    localparam int W       = STREAMS * BITS;
    localparam int TIMEOUT = 16;

    logic         aclk = 1'b0;
    logic         areset;
    logic         start, abort;
    logic [4:0]   cfg_win_len;
    logic [15:0]  cfg_frame_len;
    logic [W-1:0] s_axis_di, m_axis_di;
    logic         s_axis_vi, s_axis_ri, m_axis_vi, m_axis_ri;
    logic         avg_vo, avg_ro;
    logic [4:0]   win_len;
    logic         busy, done, err;

    always #5 aclk = ~aclk;

    win_avg_seq #(.streams(STREAMS), .bits(BITS), .timeout(TIMEOUT)) dut (
        .aclk(aclk), .areset(areset), .start(start), .abort(abort),
        .cfg_win_len(cfg_win_len), .cfg_frame_len(cfg_frame_len),
        .s_axis_di(s_axis_di), .s_axis_vi(s_axis_vi), .s_axis_ri(s_axis_ri),
        .m_axis_di(m_axis_di), .m_axis_vi(m_axis_vi), .m_axis_ri(m_axis_ri),
        .avg_vo(avg_vo), .avg_ro(avg_ro), .win_len(win_len),
        .busy(busy), .done(done), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frame progress tracked as plain counts per phase.
    typedef enum {P_IDLE, P_LOAD, P_RUN, P_DRAIN, P_DONE} phase_t;
    phase_t m_phase;
    int m_frame, m_beats, m_outs, m_win, m_err, m_idle;
    int acc_beats, done_seen;

    task automatic model_reset();
        m_phase = P_IDLE;
        m_frame = 0; m_beats = 0; m_outs = 0; m_win = 0; m_err = 0; m_idle = 0;
    endtask

    task automatic model_edge();
        bit ob, ib;
        ob = avg_vo && avg_ro;
        ib = s_axis_vi && m_axis_ri;
        if (abort) begin
            m_phase = P_IDLE; m_beats = 0; m_outs = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (start) begin
                    if (cfg_frame_len == 0) m_err = 1;
                    else begin
                        m_win = int'(cfg_win_len); m_frame = int'(cfg_frame_len);
                        m_err = 0; m_beats = 0; m_outs = 0; m_idle = 0;
                        m_phase = P_LOAD;
                    end
                end
                P_LOAD: m_phase = P_RUN;
                P_RUN: begin
                    if (ob && m_outs < m_frame) m_outs++;
                    if (ib) begin
                        m_beats++;
                        if (m_beats == m_frame) m_phase = P_DRAIN;
                    end
                end
                P_DRAIN: begin
                    if (m_outs == m_frame) m_phase = P_DONE;
                    else if (ob) begin
                        m_outs++; m_idle = 0;
                    end else begin
`ifdef WIN_AVG_SEQ_TIMEOUT_EN
                        m_idle++;
                        if (m_idle == TIMEOUT) begin
                            m_err = 1; m_phase = P_IDLE;
                        end
`endif
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    // One clock: compare everything mid-cycle, then advance the model on the edge.
    task automatic step();
        bit run;
        @(negedge aclk);
        run = (m_phase == P_RUN);
        check("busy", busy, (m_phase == P_LOAD || m_phase == P_RUN || m_phase == P_DRAIN));
        check("done", done, m_phase == P_DONE);
        check("err", err, m_err[0]);
        check("win_len", win_len, m_win[4:0]);
        check("s_axis_ri", s_axis_ri, run && m_axis_ri);
        check("m_axis_vi", m_axis_vi, run && s_axis_vi);
        check("m_axis_di", m_axis_di, s_axis_di);
        if (s_axis_vi && s_axis_ri) acc_beats++;
        if (done) done_seen++;
        @(posedge aclk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        start = 0; abort = 0; s_axis_vi = 0; m_axis_ri = 0; avg_vo = 0; avg_ro = 0;
    endtask

    task automatic begin_frame(input logic [4:0] wl, input logic [15:0] fl);
        cfg_win_len = wl; cfg_frame_len = fl; start = 1;
        step();
        start = 0;
        acc_beats = 0; done_seen = 0;
    endtask

    initial begin
        areset = 1; quiet();
        cfg_win_len = 0; cfg_frame_len = 0; s_axis_di = '0;
        model_reset();
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_win", win_len, 0);
        @(posedge aclk); #1 areset = 0;

        // Basic frame: 4 beats in, 4 averaged out, single done pulse.
        begin_frame(5'd5, 16'd4);
        s_axis_vi = 1; m_axis_ri = 1;
        for (int i = 0; i < 20 && m_phase != P_DRAIN; i++) begin
            s_axis_di = {$urandom, $urandom};
            step();
        end
        check("beats_basic", acc_beats, 4);
        check("win_basic", win_len, 5);
        s_axis_vi = 0; avg_vo = 1; avg_ro = 1;
        for (int i = 0; i < 20 && m_phase != P_IDLE; i++) step();
        avg_vo = 0;
        for (int i = 0; i < 3; i++) step();
        check("done_pulses_basic", done_seen, 1);
        check("busy_after_done", busy, 0);

        // Zero-length frame flags an error; a valid start clears it.
        begin_frame(5'd7, 16'd0);
        step();
        check("err_zero_len", err, 1);
        check("busy_zero_len", busy, 0);
        begin_frame(5'd3, 16'd2);
        check("err_cleared", err, 0);
        abort = 1; step(); abort = 0; step();

        // Ready toggling each cycle: exactly 8 beats, none after the 8th.
        begin_frame(5'd9, 16'd8);
        s_axis_vi = 1;
        for (int i = 0; i < 30; i++) begin
            m_axis_ri = 1'(i % 2);
            s_axis_di = {$urandom, $urandom};
            step();
        end
        check("beats_toggle", acc_beats, 8);
        abort = 1; step(); abort = 0; m_axis_ri = 0; step();

        // Abort on the 3rd beat: idle next cycle, no done.
        begin_frame(5'd4, 16'd8);
        s_axis_vi = 1; m_axis_ri = 1;
        for (int i = 0; i < 10 && acc_beats < 2; i++) step();
        abort = 1; step(); abort = 0;
        step();
        check("abort_s_ri", s_axis_ri, 0);
        check("abort_busy", busy, 0);
        check("abort_no_done", done_seen, 0);

        // Asynchronous reset in the middle of RUN.
        begin_frame(5'd6, 16'd8);
        for (int i = 0; i < 4; i++) step();
        areset = 1; #2;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_win", win_len, 0);
        check("arst_s_ri", s_axis_ri, 0);
        check("arst_m_vi", m_axis_vi, 0);
        model_reset();
        @(posedge aclk); #1 areset = 0;
        quiet(); step();

        // Start and abort together in IDLE: nothing latched.
        begin_frame(5'd11, 16'd1);
        abort = 1; step(); abort = 0; step();
        cfg_win_len = 5'd20; cfg_frame_len = 16'd3; start = 1; abort = 1;
        step();
        start = 0; abort = 0;
        check("start_abort_win", win_len, 11);
        check("start_abort_busy", busy, 0);
        step();

`ifdef WIN_AVG_SEQ_TIMEOUT_EN
        // Watchdog: only one of two output beats ever arrives.
        begin_frame(5'd2, 16'd2);
        s_axis_vi = 1; m_axis_ri = 1;
        for (int i = 0; i < 10 && m_phase != P_DRAIN; i++) step();
        s_axis_vi = 0; avg_vo = 1; avg_ro = 1;
        step();
        avg_vo = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        check("wd_still_busy", busy, 1);
        step();
        check("wd_busy", busy, 0);
        check("wd_err", err, 1);
        check("wd_no_done", done_seen, 0);
        quiet(); step();
`endif

        // Random frames with random handshakes, stray starts and occasional aborts.
        for (int f = 0; f < 25; f++) begin
            logic [15:0] fl;
            fl = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
            begin_frame(5'($urandom), fl);
            for (int c = 0; c < 40; c++) begin
                s_axis_di = {$urandom, $urandom};
                s_axis_vi = 1'($urandom_range(0, 1));
                m_axis_ri = 1'($urandom_range(0, 3) != 0);
                avg_vo    = 1'($urandom_range(0, 1));
                avg_ro    = 1'($urandom_range(0, 3) != 0);
                start     = 1'($urandom_range(0, 15) == 0);
                abort     = 1'($urandom_range(0, 47) == 0);
                cfg_win_len   = 5'($urandom);
                cfg_frame_len = 16'($urandom_range(0, 5));
                step();
            end
            quiet(); abort = 1; step(); abort = 0; step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
